// File: rtl/pulse_fsm_pkg.sv
// Shared types and sizing helpers for the pulse_fsm trigger-driven pulse sequencer.
package pulse_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEAD    = 2'd1,
    PHASE_A = 2'd2,
    PHASE_B = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_L_CYCLES    = 2;
  localparam int DEF_A_CYCLES    = 4;
  localparam int DEF_B_CYCLES    = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // Phase counter only has to reach (longest phase - 1), so size it from the largest count.
  function automatic int phase_width(input int l_cycles, input int a_cycles, input int b_cycles);
    int max_cycles;
    max_cycles = l_cycles;
    if (a_cycles > max_cycles) max_cycles = a_cycles;
    if (b_cycles > max_cycles) max_cycles = b_cycles;
    return (max_cycles <= 1) ? 1 : $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/pulse_fsm_gap_counter.sv
// Saturating idle-gap counter with capture register and one-cycle done strobe.
module gap_counter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  capture,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] count_val,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] count_next;

  // The capture edge is itself an idle cycle, so the captured value includes its increment.
  always_comb begin
    count_next = count_q;
    if (en && (count_q != {DATA_WIDTH{1'b1}})) begin
      count_next = count_q + DATA_WIDTH'(1);
    end
    count_d = clear ? '0 : count_next;
    data_d  = capture ? count_next : data_q;
    done_d  = capture;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign count_val = count_q;
  assign data_out  = data_q;
  assign done      = done_q;

endmodule

// File: rtl/pulse_fsm.sv
// Trigger-synchronised L/A/B pulse sequencer with inter-pulse gap meter.
// Optional sticky missed-trigger flag enabled by defining PULSE_OVERRUN_EN.
module pulse_fsm
  import pulse_fsm_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int L_CYCLES    = DEF_L_CYCLES,
  parameter int A_CYCLES    = DEF_A_CYCLES,
  parameter int B_CYCLES    = DEF_B_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s,
  output logic                  P,
  output logic                  L,
  output logic                  A,
  output logic                  B,
  output logic [DATA_WIDTH-1:0] count_val,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  overrun
);

  localparam int PHASE_W = phase_width(L_CYCLES, A_CYCLES, B_CYCLES);
  localparam logic [PHASE_W-1:0] L_LAST = PHASE_W'(L_CYCLES - 1);
  localparam logic [PHASE_W-1:0] A_LAST = PHASE_W'(A_CYCLES - 1);
  localparam logic [PHASE_W-1:0] B_LAST = PHASE_W'(B_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   trig_edge;
  state_e                 state_q, state_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic                   p_q, p_d, l_q, l_d, a_q, a_d, b_q, b_d;
  logic                   capture;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], s};
    prev_d    = sync_q[SYNC_STAGES-1];
    trig_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // PHASE_B always returns to IDLE so a trigger on its last cycle is dropped, not chained.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + PHASE_W'(1);
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (trig_edge) begin
          state_d = LEAD;
          capture = 1'b1;
        end
      end
      LEAD: begin
        if (phase_q == L_LAST) begin
          state_d = PHASE_A;
          phase_d = '0;
        end
      end
      PHASE_A: begin
        if (phase_q == A_LAST) begin
          state_d = PHASE_B;
          phase_d = '0;
        end
      end
      PHASE_B: begin
        if (phase_q == B_LAST) begin
          state_d = IDLE;
          phase_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
    p_d = (state_d != IDLE);
    l_d = (state_d == LEAD);
    a_d = (state_d == PHASE_A);
    b_d = (state_d == PHASE_B);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      phase_q <= '0;
      p_q     <= 1'b0;
      l_q     <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      phase_q <= phase_d;
      p_q     <= p_d;
      l_q     <= l_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign P = p_q;
  assign L = l_q;
  assign A = a_q;
  assign B = b_q;

  gap_counter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_gap_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (~p_q),
    .capture  (capture),
    .clear    (capture),
    .count_val(count_val),
    .data_out (data_out),
    .done     (done)
  );

`ifdef PULSE_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q | (trig_edge & p_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_fsm.sv
// Directed self-checking bench for pulse_fsm: a 32-bit instance for timing/gap checks
// and a 4-bit instance for saturation. Honours PULSE_OVERRUN_EN for the overrun expectation.
module tb_pulse_fsm;

`ifdef PULSE_OVERRUN_EN
  localparam logic EXP_OVERRUN = 1'b1;
`else
  localparam logic EXP_OVERRUN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s;
  logic        s4;
  logic        p, l, a, b, done, overrun;
  logic [31:0] count_val, data_out;
  logic        p4, l4, a4, b4, done4, overrun4;
  logic [3:0]  count4, data4;
  int          assert_count = 0;
  int          fail_count   = 0;

  always #5 clk = ~clk;

  pulse_fsm dut (
    .clk      (clk),
    .rst      (rst),
    .s        (s),
    .P        (p),
    .L        (l),
    .A        (a),
    .B        (b),
    .count_val(count_val),
    .data_out (data_out),
    .done     (done),
    .overrun  (overrun)
  );

  pulse_fsm #(
    .DATA_WIDTH(4)
  ) dut4 (
    .clk      (clk),
    .rst      (rst),
    .s        (s4),
    .P        (p4),
    .L        (l4),
    .A        (a4),
    .B        (b4),
    .count_val(count4),
    .data_out (data4),
    .done     (done4),
    .overrun  (overrun4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic s_v);
    rst = rst_v;
    s   = s_v;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Raise s now; capture lands on the third rising edge after this sample point.
  task automatic triggerAndCapture(input string tag, input bit check_data, input logic [31:0] exp_data);
    applyStimulus(1'b0, 1'b1);
    step();
    checkOutput({tag, "_p_sync1"}, 32'(p), 32'd0);
    step();
    checkOutput({tag, "_p_sync2"}, 32'(p), 32'd0);
    s = 1'b0;
    step();
    checkOutput({tag, "_p_rise"}, 32'(p), 32'd1);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_count_clr"}, count_val, 32'd0);
    if (check_data) checkOutput({tag, "_data"}, data_out, exp_data);
  endtask

  // Starts on the capture sample; walks 10 pulse cycles and the first idle cycle.
  task automatic checkPulseShape(input string tag, input int retrig_at);
    logic [3:0] exp_plab;
    for (int i = 0; i < 10; i++) begin
      if (i < 2)      exp_plab = 4'b1100;
      else if (i < 6) exp_plab = 4'b1010;
      else            exp_plab = 4'b1001;
      checkOutput({tag, "_plab"}, 32'({p, l, a, b}), 32'(exp_plab));
      if (i > 0) checkOutput({tag, "_done_low"}, 32'(done), 32'd0);
      if (i == retrig_at) s = 1'b1;
      if (i == retrig_at + 3) s = 1'b0;
      step();
    end
    checkOutput({tag, "_plab_end"}, 32'({p, l, a, b}), 32'd0);
    checkOutput({tag, "_count_resume"}, count_val, 32'd0);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0);
    s4 = 1'b0;

    // Reset held with s toggling: everything stays at zero.
    for (int i = 0; i < 6; i++) begin
      step();
      s  = ~s;
      s4 = ~s4;
      checkOutput("rst_flags", 32'({p, l, a, b, done, overrun}), 32'd0);
      checkOutput("rst_count", count_val, 32'd0);
      checkOutput("rst_data", data_out, 32'd0);
      checkOutput("rst_flags4", 32'({p4, l4, a4, b4, done4, overrun4}), 32'd0);
      checkOutput("rst_count4", 32'(count4), 32'd0);
    end

    step();
    applyStimulus(1'b0, 1'b0);
    s4 = 1'b0;
    repeat (20) step();
    checkOutput("idle_count20", count_val, 32'd20);
    checkOutput("idle_p", 32'(p), 32'd0);

    triggerAndCapture("single", 1'b1, 32'd23);
    checkPulseShape("single", -1);

    repeat (12) step();
    for (int k = 0; k < 3; k++) begin
      triggerAndCapture("periodic", (k > 0), 32'd15);
      checkPulseShape("periodic", -1);
      repeat (12) step();
    end
    checkOutput("no_overrun_yet", 32'(overrun), 32'd0);

    triggerAndCapture("retrig", 1'b1, 32'd15);
    checkPulseShape("retrig", 5);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("retrig_no_restart", 32'(p), 32'd0);
    end
    checkOutput("retrig_overrun", 32'(overrun), 32'(EXP_OVERRUN));

    repeat (7) step();
    triggerAndCapture("bexit", 1'b1, 32'd15);
    checkPulseShape("bexit", 7);
    s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("bexit_no_chain", 32'(p), 32'd0);
    end

    checkOutput("sat_count4", 32'(count4), 32'd15);
    checkOutput("sat_data4_pre", 32'(data4), 32'd0);
    s4 = 1'b1;
    step();
    step();
    s4 = 1'b0;
    step();
    checkOutput("sat_p4", 32'(p4), 32'd1);
    checkOutput("sat_done4", 32'(done4), 32'd1);
    checkOutput("sat_data4", 32'(data4), 32'd15);
    checkOutput("sat_count4_clr", 32'(count4), 32'd0);

    triggerAndCapture("mid", 1'b0, 32'd0);
    repeat (3) step();
    checkOutput("mid_in_phase_a", 32'({p, l, a, b}), 32'b1010);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_async_flags", 32'({p, l, a, b, done, overrun}), 32'd0);
    checkOutput("mid_async_count", count_val, 32'd0);
    checkOutput("mid_async_data", data_out, 32'd0);
    step();
    applyStimulus(1'b0, 1'b0);
    repeat (3) step();
    checkOutput("post_count3", count_val, 32'd3);
    triggerAndCapture("post", 1'b1, 32'd6);
    checkPulseShape("post", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/pulse_fsm.md
Name: pulse_fsm

Overview:
- Trigger-driven pulse sequencer with an integrated inter-pulse interval meter.
- Synchronises an asynchronous trigger `s` into the ADC clock domain. Each trigger rising edge launches a three-phase pulse (L, then A, then B) with aggregate flag P.
- Counts clk cycles while P is low and captures that gap count into a holding register at the start of every pulse.
- Sits between the external trigger source and the DAC/readout path.

Parameters:
- DATA_WIDTH, 32, width of gap counter and capture register.
- L_CYCLES, 2, clk cycles spent in LEAD phase (min 1).
- A_CYCLES, 4, clk cycles spent in PHASE_A (min 1).
- B_CYCLES, 4, clk cycles spent in PHASE_B (min 1).
- SYNC_STAGES, 2, trigger synchroniser depth (min 2).

Ports:
- clk  input  1  ADC clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s  input  1  asynchronous trigger.
- P  output  1  high in LEAD, PHASE_A, PHASE_B.
- L  output  1  high only in LEAD.
- A  output  1  high only in PHASE_A.
- B  output  1  high only in PHASE_B.
- count_val  output  DATA_WIDTH  live gap counter.
- data_out  output  DATA_WIDTH  last captured gap.
- done  output  1  one-cycle strobe on capture.
- overrun  output  1  sticky missed-trigger flag (see Optional Feature).

Behaviour:
- Reset values (asynchronous, active-high):
  - State = IDLE; all outputs 0.
  - Synchroniser flops and edge-detect history = 0.
- Trigger path:
  - `s` passes through SYNC_STAGES flops; one extra flop holds the previous synced value.
  - `trig_edge` = synced & ~prev.
  - With s low before clk edge k and high from edge k onward (SYNC_STAGES=2): `trig_edge` is high between edges k+1 and k+2, and P rises after edge k+2.
- State machine: IDLE -> LEAD -> PHASE_A -> PHASE_B -> IDLE.
  - IDLE -> LEAD on `trig_edge`.
  - Each non-IDLE phase lasts exactly its parameter count in cycles, tracked by a phase counter cleared on every phase entry.
  - PHASE_B exits to IDLE after B_CYCLES; it never chains directly to LEAD, even if `trig_edge` is present in that cycle.
  - `trig_edge` while P=1 is ignored (dropped).
- Outputs: registered; exactly one of L/A/B is high when P=1. P high time = L_CYCLES+A_CYCLES+B_CYCLES cycles.
- Gap counter:
  - Increments by 1 every cycle with P=0 and on the IDLE->LEAD transition edge (wrap-around forbidden: saturates at all-ones).
  - On the cycle the state enters LEAD: data_out <= count_val, count_val <= 0, done=1 for that one cycle.
  - Held while P=1.
  - Resumes counting from 0 on the first cycle after returning to IDLE.
- Reset mid-pulse: immediately forces IDLE and clears all outputs. data_out clears to 0.
- Simultaneous `trig_edge` and saturation: capture the saturated value (all-ones).

Optional Feature:
- Macro PULSE_OVERRUN_EN.
  - Defined: `overrun` sets on any `trig_edge` while P=1; it is sticky until rst.
  - Undefined: `overrun` is tied to 0 and no logic is generated.

Decomposition:
- Package pulse_fsm_pkg holds:
  - state enum (IDLE, LEAD, PHASE_A, PHASE_B), 2 bits;
  - phase-counter width constant derived from the maximum cycle parameter.
- One natural sub-module: gap_counter.
  - Contains the enable-gated saturating counter plus capture register.
  - Parameterised by DATA_WIDTH.
  - Inputs: en (=~P), capture, clear.

Test Plan:
- Reset: rst=1 with s toggling -> P/L/A/B/done/count_val/data_out all 0 throughout.
- Single trigger:
  - rst released; s rises 20 cycles after release -> P rises 3 edges after s sampled high.
  - Phase widths: L=2, A=4, B=4.
  - done pulses once; data_out equals count_val before clear.
- Periodic trigger, period 25 clk cycles:
  - P high 10 cycles.
  - From the second pulse on, data_out = 15 at every capture; count_val returns to 0 at each capture.
- Trigger during pulse: second s edge 5 cycles into pulse -> ignored, no restart, phase widths unchanged, overrun=1 with PULSE_OVERRUN_EN, 0 without.
- Saturation: DATA_WIDTH=4, no trigger for 40 cycles -> count_val holds 15; next trigger captures 15.
- Mid-pulse reset: assert rst during PHASE_A -> outputs 0 immediately (asynchronous); after release, next trigger yields a full L/A/B sequence.
